// File: rtl/speccfa_pkg.sv
// speccfa_pkg: shared FSM encoding, token constants and event record for the SpecCFA log manager.
package speccfa_pkg;
    typedef enum logic [1:0] {IDLE, WRITE_ID, WRITE_CNT, REWIND} state_t;
    localparam logic [7:0] TOKEN_TAG_DEF = 8'hBF;
    localparam int WORD_BYTES = 2;
    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] addr;
    } evt_t;
endpackage

// File: rtl/speccfa_evt_fifo.sv
// speccfa_evt_fifo: synchronous FIFO of pending detection events; push on a full FIFO succeeds only alongside a pop.
module speccfa_evt_fifo import speccfa_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  evt_t din,
    output evt_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    evt_t mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = wr_ptr == rd_ptr;
    assign full = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
    assign do_push = push && (!full || pop);
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/speccfa_log_manager.sv
// speccfa_log_manager: replaces detected CF-Log subpaths with a 2-word block token and rewinds the log pointer.
// Optional SPECCFA_REPEAT_COUNT_EN: an event contiguous with the previous token of the same id bumps its count instead.
module speccfa_log_manager import speccfa_pkg::*; #(
    parameter logic [7:0]  TOKEN_TAG    = TOKEN_TAG_DEF,
    parameter logic [15:0] LOG_MAX_ADDR = 16'hFFFE,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        detect_active,
    input  logic [7:0]  active_block_id,
    input  logic [15:0] active_block_cflog_addr,
    input  logic        cflow_hw_wen,
    output logic        log_wr_en,
    output logic [15:0] log_wr_addr,
    output logic [15:0] log_wr_data,
    output logic        log_ptr_wen,
    output logic [15:0] log_ptr_new,
    output logic        busy,
    output logic        evt_overflow,
    output logic        log_full,
    output logic        collision_err
);
    localparam logic [15:0] TOK_BYTES = 16'(2 * WORD_BYTES);
    state_t state, state_nx;
    evt_t head;
    logic full, empty, pop, fits, repeat_hit;
    logic [7:0] ev_id;
    logic [15:0] tok_addr, cnt;
    speccfa_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(detect_active), .pop(pop),
        .din({active_block_id, active_block_cflog_addr}), .dout(head), .full(full), .empty(empty)
    );
    assign pop = state == IDLE && !empty;
    // 17-bit sum so an address near the top of the map cannot wrap past the check
    assign fits = ({1'b0, head.addr} + 17'd4) <= {1'b0, LOG_MAX_ADDR};
`ifdef SPECCFA_REPEAT_COUNT_EN
    logic rec_valid;
    logic [7:0] last_id;
    logic [15:0] last_addr, last_cnt;
    assign repeat_hit = rec_valid && head.id == last_id && head.addr == last_addr + TOK_BYTES && last_cnt != 16'hFFFF;
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_valid <= 1'b0;
            last_id <= '0;
            last_addr <= '0;
            last_cnt <= '0;
        end else if (state == REWIND) begin
            rec_valid <= 1'b1;
            last_id <= ev_id;
            last_addr <= tok_addr;
            last_cnt <= cnt;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (pop && fits) state_nx = repeat_hit ? WRITE_CNT : WRITE_ID;
            WRITE_ID: state_nx = WRITE_CNT;
            WRITE_CNT: state_nx = REWIND;
            default: state_nx = IDLE;
        endcase
    end
    assign log_wr_en = state == WRITE_ID || state == WRITE_CNT;
    assign log_wr_addr = state == WRITE_ID ? tok_addr : state == WRITE_CNT ? tok_addr + 16'(WORD_BYTES) : '0;
    assign log_wr_data = state == WRITE_ID ? {TOKEN_TAG, ev_id} : state == WRITE_CNT ? cnt : '0;
    assign log_ptr_wen = state == REWIND;
    assign log_ptr_new = state == REWIND ? tok_addr + TOK_BYTES : '0;
    assign busy = state != IDLE || !empty;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ev_id <= '0;
            tok_addr <= '0;
            cnt <= '0;
            evt_overflow <= 1'b0;
            log_full <= 1'b0;
            collision_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (detect_active && full && !pop) evt_overflow <= 1'b1;
            if (pop && !fits) log_full <= 1'b1;
            if (cflow_hw_wen && busy) collision_err <= 1'b1;
            if (pop && fits) begin
                ev_id <= head.id;
`ifdef SPECCFA_REPEAT_COUNT_EN
                tok_addr <= repeat_hit ? last_addr : head.addr;
                cnt <= repeat_hit ? last_cnt + 16'd1 : 16'd1;
`else
                tok_addr <= head.addr;
                cnt <= 16'd1;
`endif
            end
        end
    end
endmodule
